ct_idu_is_aiq_lch_rdy_gen: RTL and testbench
============================================

Name: ct_idu_is_aiq_lch_rdy_gen

Overview:
- Writer side of the AIQ launch-ready bits. Each AIQ create-port source has a per-entry launch-ready register, and this block produces the values those registers load: `create{0,1}_src{0,1}_lch_rdy` on create, plus the same-cycle create0→create1 source match.
- Keeps a per-AIQ-entry record of the producer's destination preg.
- Compares every incoming source preg against live records and against the older same-cycle create0 destination.
- Sits in the IS stage beside the AIQ entry array, between rename/dispatch and the AIQ create ports.

Parameters:
- ENTRY, 8, number of AIQ entries; width of all one-hot entry and ready vectors.
- PREG_W, 7, physical register tag width.

Ports:
- forever_cpuclk  in  1  free-running clock.
- cpurst_b  in  1  asynchronous active-low reset.
- rtu_idu_flush_is  in  1  flush; clears all records.
- create0_en  in  1  create port 0 writes an AIQ entry this cycle.
- create0_entry  in  ENTRY  one-hot target entry of create0.
- create0_dst_vld  in  1  create0 instruction writes a preg.
- create0_dst_preg  in  PREG_W  create0 destination preg.
- create0_src_vld  in  2  source valid, src1..src0.
- create0_src0_preg / create0_src1_preg  in  PREG_W  create0 source pregs.
- create1_* (en, entry, dst_vld, dst_preg, src_vld, src0_preg, src1_preg)  in  same widths  port 1; always younger than create0.
- issue_en  in  1  an AIQ entry launched this cycle.
- issue_entry  in  ENTRY  one-hot launched entry.
- create0_src0_lch_rdy, create0_src1_lch_rdy  out  ENTRY  one-hot producer entry per source; zero if none.
- create1_src0_lch_rdy, create1_src1_lch_rdy  out  ENTRY  as above; includes the create0 forward.
- create1_src0_match_c0, create1_src1_match_c0  out  1  the create1 source equals the same-cycle create0 dst.
- dst_vld  out  ENTRY  registered live-record vector.

Behaviour:
- **State.** Per entry e: `rec_vld[e]` and `rec_preg[e]`. Reset (async, cpurst_b low) sets `rec_vld` to 0 immediately. `rec_preg` is don't-care at reset but is reset to 0 in the implementation.
- **Write priority per entry each clock, highest first:**
  1. flush: `rec_vld` = 0 for all entries, creates and issues ignored.
  2. create0_en with `create0_entry[e]`: `rec_vld[e]` = `create0_dst_vld`; `rec_preg[e]` = `create0_dst_preg`.
  3. create1_en with `create1_entry[e]`: same, using port 1 fields.
  4. issue_en with `issue_entry[e]`: `rec_vld[e]` = 0.
  5. otherwise hold.
- **Entry collisions.**
  - A create to an entry that is issuing in the same cycle takes the create values.
  - create0 and create1 targeting the same entry is illegal. Guard it with an assertion; create0 wins.
- **Live mask.** `live[e]` = `rec_vld[e]` & ~(issue_en & `issue_entry[e]`). A producer launching this cycle no longer blocks; its wakeup is handled elsewhere.
- **create0 srcN ready vector.** `create0_srcN_lch_rdy[e]` = `create0_en` & `create0_src_vld[N]` & `live[e]` & (`rec_preg[e]` == `create0_srcN_preg`).
- **create1 srcN match.** `create1_srcN_match_c0` = `create0_en` & `create0_dst_vld` & `create1_en` & `create1_src_vld[N]` & (`create1_srcN_preg` == `create0_dst_preg`).
- **create1 srcN ready vector.**
  - If `create1_srcN_match_c0` = 1: output `create0_entry`. The youngest producer wins and stale table hits are suppressed.
  - Otherwise: the table-match expression above, using port 1 fields.
- **Output properties.**
  - All `lch_rdy` and match outputs are combinational, with zero-cycle latency relative to the create inputs. They are zero when the port is not enabled.
  - `dst_vld` = `rec_vld`, registered.
- **Duplicate live preg.** A preg live in more than one entry is illegal (rename guarantees uniqueness). The output is then the OR of all matching entries; flag it with an assertion.
- **Create-cycle lookup.** A source is never compared against the record being written in the same cycle. Lookup uses pre-clock state, apart from the create0→create1 forward.
- **Flush.** During flush, combinational outputs are still computed. Consumers ignore them.

Test Plan:
- **Reset then create without producer:** reset, create0 entry 8'h01, src0 preg 5 → `create0_src0_lch_rdy` = 0; next cycle `dst_vld` = 8'h01 if dst_vld=1.
- **Table hit:** create0 into entry 8'h04 with dst preg 0x12; next cycle create1 src1 preg 0x12 → `create1_src1_lch_rdy` = 8'h04, `create1_src1_match_c0` = 0.
- **Same-cycle forward:** create0 entry 8'h02, dst 0x20; create1 src0 0x20 with a stale live record of 0x20 in entry 8'h40 → `create1_src0_lch_rdy` = 8'h02, `match_c0` = 1.
- **Issue masking:** entry 8'h08 holds preg 0x33; issue_en with entry 8'h08 in the same cycle that create0 src0 = 0x33 → output 0; next cycle `dst_vld[3]` = 0.
- **Create vs issue collision:** issue 8'h10 and create1 8'h10 with dst 0x44 in the same cycle → `dst_vld[4]` = 1 after the clock; a later lookup of 0x44 returns 8'h10.
- **Flush and async reset:** fill 4 entries, assert flush → `dst_vld` = 0 next cycle. Then fill again and drop cpurst_b between clock edges → `dst_vld` = 0 with no clock edge.

Source files
------------

// File: rtl/ct_idu_is_aiq_lch_rdy_gen.sv
// AIQ launch-ready writer. Each AIQ entry keeps a record of the destination
// preg its instruction produces. Incoming create sources are compared against
// the live records, and create1 sources are also compared against the
// destination of the same-cycle create0. The result is the one-hot producer
// entry that each source's launch-ready register loads.

// Per-entry record. It holds the producer's preg and answers the lookups.
module ct_idu_is_aiq_lch_rdy_entry #(
  parameter int PREG_W = 7,
  parameter int NUM_LK = 4
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          flush,
  input  logic                          c0_wr,
  input  logic                          c0_dst_vld,
  input  logic [PREG_W-1:0]             c0_dst_preg,
  input  logic                          c1_wr,
  input  logic                          c1_dst_vld,
  input  logic [PREG_W-1:0]             c1_dst_preg,
  input  logic                          issue,
  input  logic [NUM_LK-1:0][PREG_W-1:0] lk_preg,
  output logic                          rec_vld,
  output logic [NUM_LK-1:0]             hit
);
  logic [PREG_W-1:0] rec_preg;
  logic              live;

  // Record update: flush > create0 > create1 > issue > hold.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rec_vld  <= 1'b0;
      rec_preg <= '0;
    end else if (flush) begin
      rec_vld  <= 1'b0;
    end else if (c0_wr) begin
      rec_vld  <= c0_dst_vld;
      rec_preg <= c0_dst_preg;
    end else if (c1_wr) begin
      rec_vld  <= c1_dst_vld;
      rec_preg <= c1_dst_preg;
    end else if (issue) begin
      rec_vld  <= 1'b0;
    end
  end

  // A producer that launches this cycle stops blocking. Its wakeup is
  // delivered by the issue path instead.
  assign live = rec_vld & ~issue;

  for (genvar k = 0; k < NUM_LK; k++) begin : g_lk
    assign hit[k] = live & (rec_preg == lk_preg[k]);
  end
endmodule

module ct_idu_is_aiq_lch_rdy_gen #(
  parameter int ENTRY  = 8,
  parameter int PREG_W = 7
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              rtu_idu_flush_is,
  input  logic              create0_en,
  input  logic [ENTRY-1:0]  create0_entry,
  input  logic              create0_dst_vld,
  input  logic [PREG_W-1:0] create0_dst_preg,
  input  logic [1:0]        create0_src_vld,
  input  logic [PREG_W-1:0] create0_src0_preg,
  input  logic [PREG_W-1:0] create0_src1_preg,
  input  logic              create1_en,
  input  logic [ENTRY-1:0]  create1_entry,
  input  logic              create1_dst_vld,
  input  logic [PREG_W-1:0] create1_dst_preg,
  input  logic [1:0]        create1_src_vld,
  input  logic [PREG_W-1:0] create1_src0_preg,
  input  logic [PREG_W-1:0] create1_src1_preg,
  input  logic              issue_en,
  input  logic [ENTRY-1:0]  issue_entry,
  output logic [ENTRY-1:0]  create0_src0_lch_rdy,
  output logic [ENTRY-1:0]  create0_src1_lch_rdy,
  output logic [ENTRY-1:0]  create1_src0_lch_rdy,
  output logic [ENTRY-1:0]  create1_src1_lch_rdy,
  output logic              create1_src0_match_c0,
  output logic              create1_src1_match_c0,
  output logic [ENTRY-1:0]  dst_vld
);
  localparam int NUM_LK = 4;  // lookups: c0s0, c0s1, c1s0, c1s1

  logic [NUM_LK-1:0][PREG_W-1:0] lk_preg;
  logic [NUM_LK-1:0]             lk_qual;
  logic [ENTRY-1:0][NUM_LK-1:0]  hit;
  logic [NUM_LK-1:0][ENTRY-1:0]  tbl;
  logic [ENTRY-1:0]              rec_vld;

  assign lk_preg = {create1_src1_preg, create1_src0_preg,
                    create0_src1_preg, create0_src0_preg};
  assign lk_qual = {create1_en & create1_src_vld[1], create1_en & create1_src_vld[0],
                    create0_en & create0_src_vld[1], create0_en & create0_src_vld[0]};

  for (genvar e = 0; e < ENTRY; e++) begin : g_ent
    ct_idu_is_aiq_lch_rdy_entry #(.PREG_W(PREG_W), .NUM_LK(NUM_LK)) u_ent (
      .clk         (forever_cpuclk),
      .rst_b       (cpurst_b),
      .flush       (rtu_idu_flush_is),
      .c0_wr       (create0_en & create0_entry[e]),
      .c0_dst_vld  (create0_dst_vld),
      .c0_dst_preg (create0_dst_preg),
      .c1_wr       (create1_en & create1_entry[e]),
      .c1_dst_vld  (create1_dst_vld),
      .c1_dst_preg (create1_dst_preg),
      .issue       (issue_en & issue_entry[e]),
      .lk_preg     (lk_preg),
      .rec_vld     (rec_vld[e]),
      .hit         (hit[e])
    );
    for (genvar k = 0; k < NUM_LK; k++) begin : g_tp
      assign tbl[k][e] = hit[e][k] & lk_qual[k];
    end
  end

  assign dst_vld = rec_vld;

  // Same-cycle forward: create1 is younger, so a create0 destination match
  // supersedes any older table hit on the same preg.
  assign create1_src0_match_c0 = create0_en & create0_dst_vld & lk_qual[2]
                               & (create1_src0_preg == create0_dst_preg);
  assign create1_src1_match_c0 = create0_en & create0_dst_vld & lk_qual[3]
                               & (create1_src1_preg == create0_dst_preg);

  assign create0_src0_lch_rdy = tbl[0];
  assign create0_src1_lch_rdy = tbl[1];
  assign create1_src0_lch_rdy = create1_src0_match_c0 ? create0_entry : tbl[2];
  assign create1_src1_lch_rdy = create1_src1_match_c0 ? create0_entry : tbl[3];

  // Both create ports must never target the same entry.
  a_create_collide: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    (create0_en & create1_en) |-> ((create0_entry & create1_entry) == '0));

  // Rename keeps live pregs unique, so a lookup hits at most one entry.
  for (genvar k = 0; k < NUM_LK; k++) begin : g_dup
    a_dup_preg: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
      $onehot0(tbl[k]));
  end
endmodule

// File: tb/tb_ct_idu_is_aiq_lch_rdy_gen.sv
// Directed bench for the AIQ launch-ready writer. The bench drives inputs on
// the falling edge and checks the combinational outputs 1ns later. It checks
// registered state on the falling edge that follows each rising edge.
module tb_ct_idu_is_aiq_lch_rdy_gen;
  localparam int ENTRY  = 8;
  localparam int PREG_W = 7;

  logic              clk = 1'b0;
  logic              rst_b;
  logic              flush;
  logic              c0_en, c0_dv, c1_en, c1_dv, iss_en;
  logic [ENTRY-1:0]  c0_entry, c1_entry, iss_entry;
  logic [PREG_W-1:0] c0_dst, c0_s0, c0_s1, c1_dst, c1_s0, c1_s1;
  logic [1:0]        c0_sv, c1_sv;
  logic [ENTRY-1:0]  c0s0_rdy, c0s1_rdy, c1s0_rdy, c1s1_rdy, dvld;
  logic              m0, m1;

  int checks = 0;
  int errors = 0;

  ct_idu_is_aiq_lch_rdy_gen #(.ENTRY(ENTRY), .PREG_W(PREG_W)) dut (
    .forever_cpuclk        (clk),
    .cpurst_b              (rst_b),
    .rtu_idu_flush_is      (flush),
    .create0_en            (c0_en),
    .create0_entry         (c0_entry),
    .create0_dst_vld       (c0_dv),
    .create0_dst_preg      (c0_dst),
    .create0_src_vld       (c0_sv),
    .create0_src0_preg     (c0_s0),
    .create0_src1_preg     (c0_s1),
    .create1_en            (c1_en),
    .create1_entry         (c1_entry),
    .create1_dst_vld       (c1_dv),
    .create1_dst_preg      (c1_dst),
    .create1_src_vld       (c1_sv),
    .create1_src0_preg     (c1_s0),
    .create1_src1_preg     (c1_s1),
    .issue_en              (iss_en),
    .issue_entry           (iss_entry),
    .create0_src0_lch_rdy  (c0s0_rdy),
    .create0_src1_lch_rdy  (c0s1_rdy),
    .create1_src0_lch_rdy  (c1s0_rdy),
    .create1_src1_lch_rdy  (c1s1_rdy),
    .create1_src0_match_c0 (m0),
    .create1_src1_match_c0 (m1),
    .dst_vld               (dvld)
  );

  always #5 clk = ~clk;

  task automatic idle();
    flush = 0; iss_en = 0; iss_entry = '0;
    c0_en = 0; c0_entry = '0; c0_dv = 0; c0_dst = '0; c0_sv = '0; c0_s0 = '0; c0_s1 = '0;
    c1_en = 0; c1_entry = '0; c1_dv = 0; c1_dst = '0; c1_sv = '0; c1_s0 = '0; c1_s1 = '0;
  endtask

  // c0 create with a destination, then one clock edge.
  task automatic fill(input logic [ENTRY-1:0] ent, input logic [PREG_W-1:0] p);
    @(negedge clk); idle();
    c0_en = 1; c0_entry = ent; c0_dv = 1; c0_dst = p;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_b = 0; idle();
    #1;
    checks++; if (dvld !== 8'h00) begin errors++; $display("FAIL reset_dst_vld got=%h exp=00", dvld); end
    checks++; if (c0s0_rdy !== 8'h00 || m0 !== 1'b0) begin errors++; $display("FAIL reset_outs got=%h/%b exp=00/0", c0s0_rdy, m0); end
    repeat (2) @(negedge clk);
    rst_b = 1;
  endtask

  task automatic test_no_producer();
    @(negedge clk); idle();
    c0_en = 1; c0_entry = 8'h01; c0_dv = 1; c0_dst = 7'h0A; c0_sv = 2'b01; c0_s0 = 7'h05;
    #1;
    checks++; if (c0s0_rdy !== 8'h00) begin errors++; $display("FAIL no_prod_rdy got=%h exp=00", c0s0_rdy); end
    @(negedge clk); idle();
    checks++; if (dvld !== 8'h01) begin errors++; $display("FAIL no_prod_dst_vld got=%h exp=01", dvld); end
  endtask

  task automatic test_table_hit();
    fill(8'h04, 7'h12);
    @(negedge clk); idle();
    c1_en = 1; c1_entry = 8'h08; c1_dv = 0; c1_sv = 2'b10; c1_s1 = 7'h12;
    c0_sv = 2'b11; c0_s1 = 7'h12;  // create0 disabled: must stay zero
    #1;
    checks++; if (c1s1_rdy !== 8'h04) begin errors++; $display("FAIL hit_c1s1 got=%h exp=04", c1s1_rdy); end
    checks++; if (m1 !== 1'b0) begin errors++; $display("FAIL hit_match got=%b exp=0", m1); end
    checks++; if (c0s1_rdy !== 8'h00) begin errors++; $display("FAIL hit_c0_disabled got=%h exp=00", c0s1_rdy); end
    @(negedge clk); idle();
    checks++; if (dvld !== 8'h05) begin errors++; $display("FAIL hit_dst_vld got=%h exp=05", dvld); end
  endtask

  task automatic test_forward();
    fill(8'h40, 7'h20);
    @(negedge clk); idle();
    c0_en = 1; c0_entry = 8'h02; c0_dv = 1; c0_dst = 7'h20;
    c1_en = 1; c1_entry = 8'h80; c1_sv = 2'b01; c1_s0 = 7'h20;
    #1;
    checks++; if (c1s0_rdy !== 8'h02) begin errors++; $display("FAIL fwd_rdy got=%h exp=02", c1s0_rdy); end
    checks++; if (m0 !== 1'b1 || m1 !== 1'b0) begin errors++; $display("FAIL fwd_match got=%b%b exp=01", m1, m0); end
    // retire the stale 0x20 record so the preg stays unique
    @(negedge clk); idle();
    iss_en = 1; iss_entry = 8'h40;
    @(negedge clk); idle();
    checks++; if (dvld !== 8'h07) begin errors++; $display("FAIL fwd_dst_vld got=%h exp=07", dvld); end
    // create0 without a destination does not forward; the table wins
    c0_en = 1; c0_entry = 8'h20; c0_dv = 0; c0_dst = 7'h20;
    c1_en = 1; c1_entry = 8'h80; c1_sv = 2'b01; c1_s0 = 7'h20;
    #1;
    checks++; if (c1s0_rdy !== 8'h02 || m0 !== 1'b0) begin errors++; $display("FAIL nofwd got=%h/%b exp=02/0", c1s0_rdy, m0); end
    @(negedge clk); idle();
    checks++; if (dvld !== 8'h07) begin errors++; $display("FAIL nofwd_dst_vld got=%h exp=07", dvld); end
  endtask

  task automatic test_issue_mask();
    fill(8'h08, 7'h33);
    @(negedge clk); idle();
    checks++; if (dvld !== 8'h0F) begin errors++; $display("FAIL iss_pre_dst_vld got=%h exp=0F", dvld); end
    iss_en = 1; iss_entry = 8'h08;
    c0_en = 1; c0_entry = 8'h10; c0_dv = 0; c0_sv = 2'b11; c0_s0 = 7'h33; c0_s1 = 7'h12;
    #1;
    checks++; if (c0s0_rdy !== 8'h00) begin errors++; $display("FAIL iss_mask got=%h exp=00", c0s0_rdy); end
    checks++; if (c0s1_rdy !== 8'h04) begin errors++; $display("FAIL iss_other got=%h exp=04", c0s1_rdy); end
    @(negedge clk); idle();
    checks++; if (dvld !== 8'h07) begin errors++; $display("FAIL iss_dst_vld got=%h exp=07", dvld); end
  endtask

  task automatic test_collision();
    @(negedge clk); idle();
    iss_en = 1; iss_entry = 8'h10;
    c1_en = 1; c1_entry = 8'h10; c1_dv = 1; c1_dst = 7'h44;
    @(negedge clk); idle();
    checks++; if (dvld !== 8'h17) begin errors++; $display("FAIL coll_dst_vld got=%h exp=17", dvld); end
    c0_en = 1; c0_entry = 8'h20; c0_sv = 2'b01; c0_s0 = 7'h44;
    #1;
    checks++; if (c0s0_rdy !== 8'h10) begin errors++; $display("FAIL coll_lookup got=%h exp=10", c0s0_rdy); end
    @(negedge clk); idle();
  endtask

  task automatic test_flush();
    flush = 1;
    c0_en = 1; c0_entry = 8'h20; c0_dv = 1; c0_dst = 7'h70; c0_sv = 2'b01; c0_s0 = 7'h12;
    #1;
    checks++; if (c0s0_rdy !== 8'h04) begin errors++; $display("FAIL flush_comb got=%h exp=04", c0s0_rdy); end
    @(negedge clk); idle();
    checks++; if (dvld !== 8'h00) begin errors++; $display("FAIL flush_dst_vld got=%h exp=00", dvld); end
    c0_en = 1; c0_entry = 8'h01; c0_sv = 2'b01; c0_s0 = 7'h12;
    #1;
    checks++; if (c0s0_rdy !== 8'h00) begin errors++; $display("FAIL flush_lookup got=%h exp=00", c0s0_rdy); end
  endtask

  task automatic test_async_reset();
    fill(8'h80, 7'h55);
    fill(8'h01, 7'h56);
    @(negedge clk); idle();
    checks++; if (dvld !== 8'h81) begin errors++; $display("FAIL arst_pre got=%h exp=81", dvld); end
    #2 rst_b = 0;
    #1;
    checks++; if (dvld !== 8'h00) begin errors++; $display("FAIL arst_dst_vld got=%h exp=00", dvld); end
    @(negedge clk); rst_b = 1;
  endtask

  task automatic test_back_to_back();
    fill(8'h01, 7'h61);
    @(negedge clk); idle();
    c0_en = 1; c0_entry = 8'h02; c0_dv = 1; c0_dst = 7'h62;
    c1_en = 1; c1_entry = 8'h04; c1_dv = 1; c1_dst = 7'h63;
    c1_sv = 2'b11; c1_s0 = 7'h61; c1_s1 = 7'h62;
    #1;
    checks++; if (c1s0_rdy !== 8'h01 || m0 !== 1'b0) begin errors++; $display("FAIL b2b_s0 got=%h/%b exp=01/0", c1s0_rdy, m0); end
    checks++; if (c1s1_rdy !== 8'h02 || m1 !== 1'b1) begin errors++; $display("FAIL b2b_s1 got=%h/%b exp=02/1", c1s1_rdy, m1); end
    @(negedge clk); idle();
    c0_en = 1; c0_entry = 8'h08; c0_sv = 2'b11; c0_s0 = 7'h63; c0_s1 = 7'h62;
    #1;
    checks++; if (c0s0_rdy !== 8'h04 || c0s1_rdy !== 8'h02) begin errors++; $display("FAIL b2b_next got=%h/%h exp=04/02", c0s0_rdy, c0s1_rdy); end
    checks++; if (dvld !== 8'h07) begin errors++; $display("FAIL b2b_dst_vld got=%h exp=07", dvld); end
    @(negedge clk); idle();
  endtask

  initial begin
    test_reset();
    test_no_producer();
    test_table_hit();
    test_forward();
    test_issue_mask();
    test_collision();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
